// File: rtl/stream_width_downconverter_pkg.sv
// -----------------------------------------------------------------------------
// stream_width_downconverter_pkg
// Shared elaboration-time helpers for the stream width down-converter.
//   clog2     : ceiling log2 of a positive integer (0 for values <= 1)
//   idx_width : width of the slice index register, never less than one bit
// -----------------------------------------------------------------------------
package stream_width_downconverter_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // A RATIO of 1 still needs a one-bit index so the part-select stays legal.
    function automatic int idx_width(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

endpackage

// File: rtl/stream_width_downconverter.sv
// -----------------------------------------------------------------------------
// stream_width_downconverter
// Drains a wide AXI-Stream word and re-emits it as RATIO narrow beats, least
// significant slice first, at one beat per cycle with no bubble between words.
//
// Ports
//   ap_clk        in   clock, rising edge
//   ap_rst        in   synchronous reset, active high
//   in0_V_TDATA   in   wide word (IN_WIDTH)
//   in0_V_TVALID  in   wide word valid
//   in0_V_TREADY  out  ready for a wide word
//   out_V_TDATA   out  narrow beat (OUT_WIDTH), driven from the hold register
//   out_V_TVALID  out  narrow beat valid
//   out_V_TREADY  in   downstream ready
//   words_in      out  wide words accepted since reset (wraps)
//   beats_out     out  narrow beats sent since reset (wraps)
// -----------------------------------------------------------------------------
module stream_width_downconverter
    import stream_width_downconverter_pkg::*;
#(
    parameter int IN_WIDTH  = 72,
    parameter int OUT_WIDTH = 8,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic [IN_WIDTH-1:0]  in0_V_TDATA,
    input  logic                 in0_V_TVALID,
    output logic                 in0_V_TREADY,
    output logic [OUT_WIDTH-1:0] out_V_TDATA,
    output logic                 out_V_TVALID,
    input  logic                 out_V_TREADY,
    output logic [CNT_WIDTH-1:0] words_in,
    output logic [CNT_WIDTH-1:0] beats_out
);

    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int IDX_W = idx_width(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    logic [IN_WIDTH-1:0]  hold_r;
    logic [IDX_W-1:0]     idx_r;
    logic                 full_r;
    logic [CNT_WIDTH-1:0] words_r;
    logic [CNT_WIDTH-1:0] beats_r;

    logic [IN_WIDTH-1:0]  hold_nxt_s;
    logic [IDX_W-1:0]     idx_nxt_s;
    logic                 full_nxt_s;
    logic                 last_s;
    logic                 in_xfer_s;
    logic                 out_xfer_s;

    // Handshake decode; the only combinational path is out_V_TREADY -> in0_V_TREADY,
    // which lets a new word load on the same edge the final slice leaves.
    always_comb begin
        last_s       = (idx_r == LAST_IDX);
        in0_V_TREADY = !full_r || (out_V_TREADY && last_s);
        in_xfer_s    = in0_V_TVALID && in0_V_TREADY;
        out_xfer_s   = full_r && out_V_TREADY;
    end

    // Next-state for hold/index/full; an input transfer takes priority because it
    // can only coincide with the final output slice of the previous word.
    always_comb begin
        hold_nxt_s = hold_r;
        idx_nxt_s  = idx_r;
        full_nxt_s = full_r;
        if (in_xfer_s) begin
            hold_nxt_s = in0_V_TDATA;
            idx_nxt_s  = {IDX_W{1'b0}};
            full_nxt_s = 1'b1;
        end else if (out_xfer_s) begin
            if (last_s) begin
                idx_nxt_s  = {IDX_W{1'b0}};
                full_nxt_s = 1'b0;
            end else begin
                idx_nxt_s  = idx_r + IDX_W'(1);
            end
        end else begin
            full_nxt_s = full_r;
        end
    end

    // State and debug counter registers with synchronous reset.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            hold_r  <= {IN_WIDTH{1'b0}};
            idx_r   <= {IDX_W{1'b0}};
            full_r  <= 1'b0;
            words_r <= {CNT_WIDTH{1'b0}};
            beats_r <= {CNT_WIDTH{1'b0}};
        end else begin
            hold_r  <= hold_nxt_s;
            idx_r   <= idx_nxt_s;
            full_r  <= full_nxt_s;
            words_r <= words_r + (in_xfer_s  ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
            beats_r <= beats_r + (out_xfer_s ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
        end
    end

    // Output beat is a registered slice of the hold word; nothing from in0 reaches it.
    always_comb begin
        out_V_TVALID = full_r;
        out_V_TDATA  = hold_r[int'(idx_r) * OUT_WIDTH +: OUT_WIDTH];
        words_in     = words_r;
        beats_out    = beats_r;
    end

endmodule

// File: tb/tb_stream_width_downconverter.sv
// -----------------------------------------------------------------------------
// tb_stream_width_downconverter
// Scoreboard bench: a 72->8 instance (RATIO 9) and a 72->72 instance (RATIO 1).
// Stimulus tasks push expected beats into queues; negedge monitors pop and
// compare whenever a beat is transferred.
// -----------------------------------------------------------------------------
module tb_stream_width_downconverter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [71:0] in_data  = 72'h0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] words_in;
    logic [31:0] beats_out;

    logic [71:0] r1_in_data  = 72'h0;
    logic        r1_in_valid = 1'b0;
    logic        r1_in_ready;
    logic [71:0] r1_out_data;
    logic        r1_out_valid;
    logic        r1_out_ready = 1'b1;
    logic [31:0] r1_words_in;
    logic [31:0] r1_beats_out;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  exp_q[$];
    logic [71:0] exp1_q[$];
    int exp_words = 0;
    int exp_beats = 0;
    int exp1_words = 0;
    int exp1_beats = 0;

    int ready_mode  = 0;   // 0: always ready, 1: random 50%, other: stalled
    int ready1_mode = 0;

    always #5 clk = ~clk;

    stream_width_downconverter #(.IN_WIDTH(72), .OUT_WIDTH(8), .CNT_WIDTH(32)) u_dut (
        .ap_clk       (clk),
        .ap_rst       (rst),
        .in0_V_TDATA  (in_data),
        .in0_V_TVALID (in_valid),
        .in0_V_TREADY (in_ready),
        .out_V_TDATA  (out_data),
        .out_V_TVALID (out_valid),
        .out_V_TREADY (out_ready),
        .words_in     (words_in),
        .beats_out    (beats_out)
    );

    stream_width_downconverter #(.IN_WIDTH(72), .OUT_WIDTH(72), .CNT_WIDTH(32)) u_dut1 (
        .ap_clk       (clk),
        .ap_rst       (rst),
        .in0_V_TDATA  (r1_in_data),
        .in0_V_TVALID (r1_in_valid),
        .in0_V_TREADY (r1_in_ready),
        .out_V_TDATA  (r1_out_data),
        .out_V_TVALID (r1_out_valid),
        .out_V_TREADY (r1_out_ready),
        .words_in     (r1_words_in),
        .beats_out    (r1_beats_out)
    );

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    // Downstream ready generators, updated just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
        case (ready1_mode)
            0:       r1_out_ready = 1'b1;
            1:       r1_out_ready = 1'($urandom_range(0, 1));
            default: r1_out_ready = 1'b0;
        endcase
    end

    // Monitor for the RATIO=9 instance: scoreboard pop plus stall-stability check.
    logic       stall_prev = 1'b0;
    logic [7:0] data_prev;
    logic [7:0] mon_exp;
    always @(negedge clk) begin
        if (!rst) begin
            if (stall_prev) begin
                check("stall_valid", 72'(out_valid), 72'h1);
                check("stall_data", 72'(out_data), 72'(data_prev));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", out_data, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("beat", 72'(out_data), 72'(mon_exp));
                    exp_beats++;
                end
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Monitor for the RATIO=1 instance.
    logic        stall1_prev = 1'b0;
    logic [71:0] data1_prev;
    logic [71:0] mon1_exp;
    always @(negedge clk) begin
        if (!rst) begin
            if (stall1_prev) begin
                check("r1_stall_valid", 72'(r1_out_valid), 72'h1);
                check("r1_stall_data", r1_out_data, data1_prev);
            end
            if (r1_out_valid && r1_out_ready) begin
                if (exp1_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL r1_unexpected_beat: got %0h expected none at %0t", r1_out_data, $time);
                end else begin
                    mon1_exp = exp1_q.pop_front();
                    check("r1_beat", r1_out_data, mon1_exp);
                    exp1_beats++;
                end
            end
            stall1_prev = r1_out_valid && !r1_out_ready;
            data1_prev  = r1_out_data;
        end else begin
            stall1_prev = 1'b0;
        end
    end

    // Offer one word (caller sits at posedge+1); returns cycles until acceptance.
    task automatic send_word(input bit sel, input logic [71:0] d, output int waited);
        bit acc;
        acc    = 1'b0;
        waited = 0;
        if (sel) begin
            r1_in_data  = d;
            r1_in_valid = 1'b1;
        end else begin
            in_data  = d;
            in_valid = 1'b1;
        end
        while (!acc && waited < 500) begin
            @(negedge clk);
            acc = sel ? r1_in_ready : in_ready;
            if (acc) begin
                if (sel) begin
                    exp1_q.push_back(d);
                    exp1_words++;
                end else begin
                    for (int k = 0; k < 9; k++) exp_q.push_back(d[k*8 +: 8]);
                    exp_words++;
                end
            end
            align();
            waited++;
        end
        if (sel) r1_in_valid = 1'b0;
        else     in_valid    = 1'b0;
        if (!acc) check("send_timeout", 72'(waited), 72'h0);
    endtask

    // Let the instance empty out; counts cycles with a valid beat. Ends at posedge+1.
    task automatic drain(input bit sel, output int vcnt);
        int n;
        n    = 0;
        vcnt = 0;
        while (n < 6000) begin
            @(negedge clk);
            if (sel ? r1_out_valid : out_valid) vcnt++;
            else if ((sel ? exp1_q.size() : exp_q.size()) == 0) break;
            n++;
        end
        if (n >= 6000) check("drain_timeout", 72'(n), 72'h0);
        align();
    endtask

    function automatic logic [71:0] rand72();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[71:0];
    endfunction

    int w;
    int vc;
    int k3;
    int bad3;
    int base;
    int guard;

    initial begin
        // T1: reset held three cycles with input valid
        in_valid = 1'b1;
        in_data  = 72'hA5A5A5A5A5A5A5A5A5;
        repeat (3) begin
            @(negedge clk);
            check("t1_rst_valid", 72'(out_valid), 72'h0);
            check("t1_rst_words", 72'(words_in), 72'h0);
        end
        align();
        in_valid = 1'b0;
        rst      = 1'b0;
        @(negedge clk);
        check("t1_ready", 72'(in_ready), 72'h1);
        check("t1_valid", 72'(out_valid), 72'h0);
        check("t1_data", 72'(out_data), 72'h0);
        check("t1_beats", 72'(beats_out), 72'h0);
        check("t1_r1_ready", 72'(r1_in_ready), 72'h1);
        align();

        // T2: single word, LSB slice first, one-cycle latency
        ready_mode = 0;
        send_word(1'b0, 72'h112233445566778899, w);
        check("t2_latency", 72'(out_valid), 72'h1);
        check("t2_first_beat", 72'(out_data), 72'h99);
        drain(1'b0, vc);
        check("t2_beat_cycles", 72'(vc), 72'd9);
        check("t2_words", 72'(words_in), 72'd1);
        check("t2_beats", 72'(beats_out), 72'd9);

        // T3: four words back to back, sink always ready
        bad3 = 0;
        k3   = 0;
        fork
            begin
                send_word(1'b0, 72'h0F0E0D0C0B0A090807, w);
                send_word(1'b0, 72'h1F1E1D1C1B1A191817, w);
                send_word(1'b0, 72'h2F2E2D2C2B2A292827, w);
                send_word(1'b0, 72'h3F3E3D3C3B3A393837, w);
            end
            begin
                guard = 0;
                @(negedge clk);
                while (!out_valid && guard < 20) begin
                    @(negedge clk);
                    guard++;
                end
                while (out_valid && k3 < 60) begin
                    if (in_ready !== ((k3 % 9) == 8)) bad3++;
                    k3++;
                    @(negedge clk);
                end
            end
        join
        check("t3_run_length", 72'(k3), 72'd36);
        check("t3_ready_pattern", 72'(bad3), 72'h0);
        drain(1'b0, vc);
        check("t3_words", 72'(words_in), 72'd5);
        check("t3_beats", 72'(beats_out), 72'd45);

        // T4: 200 random words under random backpressure
        ready_mode = 1;
        for (int i = 0; i < 200; i++) begin
            send_word(1'b0, rand72(), w);
        end
        check("t4_invariant", 72'(beats_out), 72'(9 * exp_words - exp_q.size()));
        drain(1'b0, vc);
        check("t4_words", 72'(words_in), 72'd205);
        check("t4_beats", 72'(beats_out), 72'd1845);
        check("t4_model_beats", 72'(beats_out), 72'(exp_beats));

        // T5: reset after four beats of a word discards the rest
        ready_mode = 0;
        align();
        base = exp_beats;
        send_word(1'b0, 72'hDEADBEEFCAFEF00D42, w);
        guard = 0;
        while ((exp_beats - base) < 4 && guard < 50) begin
            align();
            guard++;
        end
        check("t5_beats_before_rst", 72'(exp_beats - base), 72'd4);
        rst = 1'b1;
        exp_q.delete();
        align();
        rst        = 1'b0;
        exp_words  = 0;
        exp_beats  = 0;
        exp1_words = 0;
        exp1_beats = 0;
        check("t5_valid_after_rst", 72'(out_valid), 72'h0);
        check("t5_words_after_rst", 72'(words_in), 72'h0);
        check("t5_beats_after_rst", 72'(beats_out), 72'h0);
        send_word(1'b0, 72'h807060504030201000, w);
        check("t5_first_beat", 72'(out_data), 72'h00);
        drain(1'b0, vc);
        check("t5_words", 72'(words_in), 72'd1);
        check("t5_beats", 72'(beats_out), 72'd9);

        // T6: RATIO=1 build, passthrough with one-cycle latency and full throughput
        ready1_mode = 0;
        align();
        send_word(1'b1, 72'h0123456789ABCDEF01, w);
        check("t6_latency", 72'(r1_out_valid), 72'h1);
        check("t6_data", r1_out_data, 72'h0123456789ABCDEF01);
        for (int i = 0; i < 5; i++) begin
            send_word(1'b1, rand72(), w);
            check("t6_throughput", 72'(w), 72'd1);
        end
        ready1_mode = 1;
        for (int i = 0; i < 20; i++) begin
            send_word(1'b1, rand72(), w);
        end
        drain(1'b1, vc);
        check("t6_words", 72'(r1_words_in), 72'd26);
        check("t6_beats", 72'(r1_beats_out), 72'd26);
        check("t6_model_beats", 72'(r1_beats_out), 72'(exp1_beats));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
